pipe_if_id_queue: RTL and testbench
===================================

// Module: pipe_if_id_queue
// PURPOSE
//   Parametrised IF->ID instruction queue, DEPTH entries of {pc, inst}.
//   Decouples fetch from decode: IF pushes fetched instructions with a valid/ready
//   handshake, and ID pops from the head.
//   discard flushes every entry, e.g. on branch mispredict or jump.
//   When the queue is empty it presents a zero bubble (pc=0, inst=0), so ID sees a nop.
// PARAMETERS
//   ADDR_WIDTH   32          width of pc
//   INST_WIDTH   32          width of inst
//   DEPTH        4           entries; power of 2, >= 2
//   AFULL_LEVEL  DEPTH-1     almost_full asserts when count >= AFULL_LEVEL; range 1..DEPTH
// PORTS
//   clock        in   1                    clock, rising edge
//   reset        in   1                    synchronous, active-high
//   discard      in   1                    flush all entries at next edge
//   in_valid     in   1                    IF offers {in_pc, in_inst}
//   in_ready     out  1                    queue not full
//   in_pc        in   ADDR_WIDTH           pc of fetched instruction
//   in_inst      in   INST_WIDTH           fetched instruction
//   out_valid    out  1                    head entry present
//   out_ready    in   1                    ID accepts head (low = ID stall)
//   out_pc       out  ADDR_WIDTH           head pc, 0 when empty
//   out_inst     out  INST_WIDTH           head inst, 0 when empty
//   count        out  $clog2(DEPTH+1)      occupied entries, 0..DEPTH
//   almost_full  out  1                    count >= AFULL_LEVEL
// BEHAVIOUR
//   - Storage: circular buffer with head and tail pointers of $clog2(DEPTH) bits.
//     Pointers wrap from DEPTH-1 to 0.
//   - push = in_valid && in_ready; pop = out_valid && out_ready.
//     Both are evaluated on the same edge.
//   - in_ready  = (count != DEPTH); combinational from state only, with no path from in_valid.
//   - out_valid = (count != 0). out_pc and out_inst show mem[head] when count != 0, else 0.
//     All three are combinational from registers only.
//   - Latency: an entry pushed at edge N is visible on the outputs after edge N.
//     There is no same-cycle bypass.
//   - Push and pop in the same cycle: tail and head both advance and count is unchanged.
//     This is legal at any 0 < count < DEPTH.
//   - Full: in_ready = 0, so in_valid is ignored and no overwrite occurs.
//     A pop from full frees a slot that is visible the next cycle.
//   - Empty: out_valid = 0, so out_ready is ignored and outputs stay the 0 bubble.
//   - discard (priority over push/pop): at the next edge head = tail = 0 and count = 0.
//     A push or pop requested in that same cycle is dropped.
//     Outputs read as the bubble the following cycle.
//   - reset (priority over all): head = tail = count = 0.
//     After reset: in_ready = 1, out_valid = 0, out_pc = 0, out_inst = 0, count = 0.
//     almost_full = (AFULL_LEVEL == 0), i.e. 0 for legal parameters.
//     Reset mid-operation discards the contents exactly like discard.
//   - count changes: +1 on push-only, -1 on pop-only, unchanged on both or neither.
//     count never exceeds DEPTH and never underflows.
//   - Storage contents need no reset; outputs are masked to 0 when empty.
// TESTING
//   1. Reset, then idle:
//      -> out_valid=0, out_pc=0, out_inst=0, in_ready=1, count=0, almost_full=0.
//   2. Push pc=0x0/inst=0x00000013 and pc=0x4/inst=0x00a00093 with out_ready=0:
//      -> count=2, out_pc=0x0 held.
//      Then out_ready=1 for two cycles:
//      -> out_pc shows 0x0 then 0x4, then bubble; count=0.
//   3. DEPTH=4: push 4 entries with out_ready=0:
//      -> in_ready=0, almost_full=1 from count=3.
//      A 5th in_valid is ignored and count stays 4.
//      Then one pop: in_ready=1 on the next cycle.
//   4. Steady stream with in_valid=1, out_ready=1 for 20 cycles, pcs 0x0..0x4C step 4:
//      -> outputs appear in order with no loss or duplication.
//      count stays 1 after the first push; pointers wrap several times.
//   5. count=3 with push and pop asserted together with discard=1:
//      -> next cycle count=0 and out_valid=0.
//      The pushed entry is never seen at the outputs.
//   6. Reset asserted with count=2, in_valid=1:
//      -> next cycle count=0 and outputs at the bubble.
//      After reset deasserts, the first push is the first entry popped.

Source files
------------

// File: rtl/pipe_if_id_queue.sv
// IF->ID instruction queue: a DEPTH-entry circular buffer of {pc, inst}.
// Fetch pushes with a valid/ready handshake and decode pops from the head.
// A discard flushes every entry, for example on a mispredict. An empty queue
// presents a zero bubble, so decode sees a nop.
module pipe_if_id_queue #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INST_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         discard,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_WIDTH-1:0]        in_pc,
    input  logic [INST_WIDTH-1:0]        in_inst,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_WIDTH-1:0]        out_pc,
    output logic [INST_WIDTH-1:0]        out_inst,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LEVEL);

    logic [ADDR_WIDTH-1:0] pc_mem_r   [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem_r [DEPTH];
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [CNT_W-1:0]      count_r;

    logic                  in_ready_s;
    logic                  out_valid_s;
    logic                  push_s;
    logic                  pop_s;

    // Handshake status decoded from the occupancy register only, so neither
    // ready nor valid has a combinational path from the opposite side.
    always_comb begin
        in_ready_s  = (count_r != FULL_C);
        out_valid_s = (count_r != {CNT_W{1'b0}});
        push_s      = in_valid && in_ready_s;
        pop_s       = out_valid_s && out_ready;
    end

    // Head entry with the zero bubble substituted while the queue is empty.
    always_comb begin
        out_pc   = {ADDR_WIDTH{1'b0}};
        out_inst = {INST_WIDTH{1'b0}};
        if (out_valid_s) begin
            out_pc   = pc_mem_r[head_r];
            out_inst = inst_mem_r[head_r];
        end else begin
            out_pc   = {ADDR_WIDTH{1'b0}};
            out_inst = {INST_WIDTH{1'b0}};
        end
    end

    // Entry storage; it has no reset because the empty mask hides stale data.
    always_ff @(posedge clock) begin
        if (push_s && !discard && !reset) begin
            pc_mem_r[tail_r]   <= in_pc;
            inst_mem_r[tail_r] <= in_inst;
        end
    end

    // Pointer and occupancy update. Reset and discard both empty the queue
    // and drop any push or pop requested in the same cycle. The pointers wrap
    // naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (discard) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_s;
    assign count       = count_r;
    assign almost_full = (count_r >= AFULL_C);

endmodule

// File: tb/tb_pipe_if_id_queue.sv
// Self-checking bench for pipe_if_id_queue.
// The reference model is a plain queue of {pc, inst} words.
module tb_pipe_if_id_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        discard = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = 32'h0;
    logic [31:0] in_inst = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;
    logic        almost_full;

    int checks = 0;
    int errors = 0;

    logic [63:0] q_m[$];

    pipe_if_id_queue #(
        .ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(DEPTH), .AFULL_LEVEL(DEPTH - 1)
    ) dut (
        .clock(clock), .reset(reset), .discard(discard),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .count(count), .almost_full(almost_full)
    );

    always #5 clock = ~clock;

    // Expected values derived from the model queue.
    function automatic logic [63:0] head_m();
        logic [63:0] h;
        h = 64'h0;
        if (q_m.size() > 0) h = q_m[0];
        return h;
    endfunction

    function automatic int size_m();
        return q_m.size();
    endfunction

    // Apply one cycle of stimulus and advance the model; this task makes no comparisons.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic rdy, input logic disc, input logic rst);
        logic push_m, pop_m;
        in_valid = v; in_pc = pc; in_inst = inst;
        out_ready = rdy; discard = disc; reset = rst;
        push_m = v && (q_m.size() < DEPTH);
        pop_m  = rdy && (q_m.size() > 0);
        @(posedge clock);
        #1;
        if (rst || disc) begin
            q_m.delete();
        end else begin
            if (pop_m) void'(q_m.pop_front());
            if (push_m) q_m.push_back({pc, inst});
        end
        in_valid = 1'b0; out_ready = 1'b0; discard = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got %0h want 0", out_pc); end
        checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_inst got %0h want 0", out_inst); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %0b want 0", almost_full); end
    endtask

    task automatic test_push_pop();
        cycle(1'b1, 32'h0, 32'h00000013, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h4, 32'h00a00093, 1'b0, 1'b0, 1'b0);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL pp_count got %0d want 2", count); end
        checks++; if (out_pc !== 32'h0 || out_inst !== 32'h00000013 || out_valid !== 1'b1)
            begin errors++; $display("FAIL pp_head got %0h/%0h want 0/13", out_pc, out_inst); end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (out_pc !== 32'h4 || out_inst !== 32'h00a00093)
            begin errors++; $display("FAIL pp_second got %0h/%0h want 4/a00093", out_pc, out_inst); end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0 || count !== 3'd0)
            begin errors++; $display("FAIL pp_bubble got v=%0b pc=%0h cnt=%0d want 0/0/0", out_valid, out_pc, count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 32'h100 + 32'(i * 4), $urandom, 1'b0, 1'b0, 1'b0);
            checks++; if (almost_full !== (i + 1 >= DEPTH - 1))
                begin errors++; $display("FAIL full_afull[%0d] got %0b want %0b", i, almost_full, (i + 1 >= DEPTH - 1)); end
        end
        checks++; if (in_ready !== 1'b0 || count !== 3'd4)
            begin errors++; $display("FAIL full_state got rdy=%0b cnt=%0d want 0/4", in_ready, count); end
        cycle(1'b1, 32'hdead, 32'hbeef, 1'b0, 1'b0, 1'b0);
        checks++; if (count !== 3'd4 || out_pc !== 32'h100)
            begin errors++; $display("FAIL full_ignore got cnt=%0d pc=%0h want 4/100", count, out_pc); end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b1 || count !== 3'd3 || out_pc !== 32'h104)
            begin errors++; $display("FAIL full_pop got rdy=%0b cnt=%0d pc=%0h want 1/3/104", in_ready, count, out_pc); end
        // Drain the rest and confirm the ignored entry never shows up.
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL full_drain got cnt=%0d v=%0b want 0/0", count, out_valid); end
    endtask

    task automatic test_stream();
        logic [63:0] h;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 32'(i * 4), $urandom, 1'b1, 1'b0, 1'b0);
            h = head_m();
            checks++; if (count !== 3'd1 || out_pc !== 32'(i * 4) || out_inst !== h[31:0])
                begin errors++; $display("FAIL stream[%0d] got cnt=%0d pc=%0h inst=%0h want 1/%0h/%0h",
                                         i, count, out_pc, out_inst, i * 4, h[31:0]); end
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL stream_end got cnt=%0d v=%0b want 0/0", count, out_valid); end
    endtask

    task automatic test_discard();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h200 + 32'(i * 4), $urandom, 1'b0, 1'b0, 1'b0);
        checks++; if (count !== 3'd3)
            begin errors++; $display("FAIL disc_fill got %0d want 3", count); end
        cycle(1'b1, 32'h5555, 32'h6666, 1'b1, 1'b1, 1'b0);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0)
            begin errors++; $display("FAIL disc_flush got cnt=%0d v=%0b pc=%0h want 0/0/0", count, out_valid, out_pc); end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0 || out_inst !== 32'h0)
            begin errors++; $display("FAIL disc_dropped got v=%0b inst=%0h want 0/0", out_valid, out_inst); end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 32'h300, 32'h1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h304, 32'h2, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h308, 32'h3, 1'b0, 1'b0, 1'b1);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL rstmid got cnt=%0d v=%0b pc=%0h want 0/0/0", count, out_valid, out_pc); end
        cycle(1'b1, 32'h400, 32'h77, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h404, 32'h88, 1'b0, 1'b0, 1'b0);
        checks++; if (out_pc !== 32'h400 || out_inst !== 32'h77)
            begin errors++; $display("FAIL rstmid_first got %0h/%0h want 400/77", out_pc, out_inst); end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (out_pc !== 32'h404)
            begin errors++; $display("FAIL rstmid_second got %0h want 404", out_pc); end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [63:0] h;
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 99) == 0);
            h = head_m();
            checks++;
            if (count !== 3'(size_m()) || out_valid !== (size_m() > 0) || in_ready !== (size_m() < DEPTH) ||
                almost_full !== (size_m() >= DEPTH - 1) || out_pc !== h[63:32] || out_inst !== h[31:0]) begin
                errors++;
                $display("FAIL random[%0d] got cnt=%0d v=%0b r=%0b af=%0b pc=%0h inst=%0h want cnt=%0d pc=%0h inst=%0h",
                         i, count, out_valid, in_ready, almost_full, out_pc, out_inst, size_m(), h[63:32], h[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_full();
        test_stream();
        test_discard();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
